// File: rtl/bp_predictor.sv
// bp_predictor: fetch-side branch predictor (1024x2b PHT, 128-entry direct-mapped BTB), 1-cycle lookup, write-first bypass.
// Define BP_PERF_CNT_EN to add saturating lookup/hit/BTB-write counters.
module bp_predictor #(
   parameter int         PHT_DEPTH = 1024,
   parameter int         BTB_DEPTH = 128,
   parameter int         BTB_TAG_W = 22,
   parameter logic [1:0] PHT_INIT  = 2'b01
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fs_req_i,
   input  logic [31:0] fs_pc_i,
   input  logic        fs_hold_i,
   input  logic [12:0] pht_wbus_i,
   input  logic [62:0] btb_wbus_i,
   output logic        pred_valid_o,
   output logic [31:0] pred_pc_o,
   output logic        btb_hit_o,
   output logic [31:0] predict_target_o,
   output logic [1:0]  pht_curr_state_o,
   output logic        predict_taken_o
`ifdef BP_PERF_CNT_EN
   ,
   output logic [31:0] lookup_cnt_o,
   output logic [31:0] btb_hit_cnt_o,
   output logic [31:0] btb_wr_cnt_o
`endif
);
   localparam int PIW = $clog2(PHT_DEPTH);
   localparam int BIW = $clog2(BTB_DEPTH);

   logic                 pht_we;
   logic [PIW-1:0]       pht_widx;
   logic [1:0]           pht_wst;
   logic                 btb_we;
   logic                 btb_wv;
   logic [BIW-1:0]       btb_waddr;
   logic [BTB_TAG_W-1:0] btb_wtag;
   logic [31:0]          btb_wtgt;

   assign {pht_we, pht_widx, pht_wst} = pht_wbus_i;
   assign {btb_we, btb_wv, btb_waddr, btb_wtag, btb_wtgt} = btb_wbus_i;

   logic [PHT_DEPTH-1:0][1:0] pht_q;
   logic [BTB_DEPTH-1:0]      btb_valid_q;
   logic [BTB_TAG_W-1:0]      btb_tag_q [BTB_DEPTH];
   logic [31:0]               btb_tgt_q [BTB_DEPTH];

   logic [PIW-1:0]       l_pidx;
   logic [BIW-1:0]       l_bidx;
   logic [BTB_TAG_W-1:0] l_tag;
   logic                 pht_byp;
   logic                 btb_byp;
   logic [1:0]           rd_st;
   logic                 rd_v;
   logic [BTB_TAG_W-1:0] rd_tag;
   logic [31:0]          rd_tgt;
   logic                 hit;

   assign l_pidx = fs_pc_i[PIW+2:3];
   assign l_bidx = fs_pc_i[BIW-1:0];
   assign l_tag  = fs_pc_i[BIW+BTB_TAG_W-1:BIW];

   // Same-cycle writes to the looked-up entry win so tight loops see their own update.
   assign pht_byp = pht_we & (pht_widx == l_pidx);
   assign btb_byp = btb_we & (btb_waddr == l_bidx);
   assign rd_st   = pht_byp ? pht_wst : pht_q[l_pidx];
   assign rd_v    = btb_byp ? btb_wv : btb_valid_q[l_bidx];
   assign rd_tag  = btb_byp ? btb_wtag : btb_tag_q[l_bidx];
   assign rd_tgt  = btb_byp ? btb_wtgt : btb_tgt_q[l_bidx];
   assign hit     = rd_v & (rd_tag == l_tag);

   always_ff @(posedge clk) begin
      if (reset) begin
         pht_q       <= {PHT_DEPTH{PHT_INIT}};
         btb_valid_q <= '0;
      end else begin
         if (pht_we) pht_q[pht_widx] <= pht_wst;
         if (btb_we) btb_valid_q[btb_waddr] <= btb_wv;
      end
   end

   always_ff @(posedge clk) begin
      if (btb_we) begin
         btb_tag_q[btb_waddr] <= btb_wtag;
         btb_tgt_q[btb_waddr] <= btb_wtgt;
      end
   end

   logic        pred_valid_q, pred_valid_d;
   logic [31:0] pred_pc_q, pred_pc_d;
   logic        btb_hit_q, btb_hit_d;
   logic [31:0] tgt_q, tgt_d;
   logic [1:0]  st_q, st_d;

   always_comb begin
      pred_valid_d = fs_hold_i ? pred_valid_q : fs_req_i;
      pred_pc_d    = fs_hold_i ? pred_pc_q : (fs_req_i ? fs_pc_i : '0);
      btb_hit_d    = fs_hold_i ? btb_hit_q : (fs_req_i & hit);
      tgt_d        = fs_hold_i ? tgt_q : ((fs_req_i & hit) ? rd_tgt : '0);
      st_d         = fs_hold_i ? st_q : (fs_req_i ? rd_st : '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pred_valid_q <= 1'b0;
         pred_pc_q    <= '0;
         btb_hit_q    <= 1'b0;
         tgt_q        <= '0;
         st_q         <= '0;
      end else begin
         pred_valid_q <= pred_valid_d;
         pred_pc_q    <= pred_pc_d;
         btb_hit_q    <= btb_hit_d;
         tgt_q        <= tgt_d;
         st_q         <= st_d;
      end
   end

   assign pred_valid_o     = pred_valid_q;
   assign pred_pc_o        = pred_pc_q;
   assign btb_hit_o        = btb_hit_q;
   assign predict_target_o = tgt_q;
   assign pht_curr_state_o = st_q;
   assign predict_taken_o  = btb_hit_q & st_q[1];

`ifdef BP_PERF_CNT_EN
   logic        accept;
   logic [31:0] lookup_cnt_q, hit_cnt_q, wr_cnt_q;

   assign accept = fs_req_i & ~fs_hold_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         lookup_cnt_q <= '0;
         hit_cnt_q    <= '0;
         wr_cnt_q     <= '0;
      end else begin
         if (accept && !(&lookup_cnt_q)) lookup_cnt_q <= lookup_cnt_q + 32'd1;
         if (accept && hit && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (btb_we && !(&wr_cnt_q)) wr_cnt_q <= wr_cnt_q + 32'd1;
      end
   end

   assign lookup_cnt_o  = lookup_cnt_q;
   assign btb_hit_cnt_o = hit_cnt_q;
   assign btb_wr_cnt_o  = wr_cnt_q;
`endif
endmodule

// File: tb/tb_bp_predictor.sv
// tb_bp_predictor: table-driven vectors plus a model-driven random phase, checked through an expected-result queue.
module tb_bp_predictor;
   logic        clk = 1'b0;
   logic        reset, fs_req_i, fs_hold_i;
   logic [31:0] fs_pc_i;
   logic [12:0] pht_wbus_i;
   logic [62:0] btb_wbus_i;
   logic        pred_valid_o, btb_hit_o, predict_taken_o;
   logic [31:0] pred_pc_o, predict_target_o;
   logic [1:0]  pht_curr_state_o;
`ifdef BP_PERF_CNT_EN
   logic [31:0] lookup_cnt_o, btb_hit_cnt_o, btb_wr_cnt_o;
`endif

   always #5 clk = ~clk;

   bp_predictor dut (
      .clk(clk), .reset(reset), .fs_req_i(fs_req_i), .fs_pc_i(fs_pc_i), .fs_hold_i(fs_hold_i),
      .pht_wbus_i(pht_wbus_i), .btb_wbus_i(btb_wbus_i),
      .pred_valid_o(pred_valid_o), .pred_pc_o(pred_pc_o), .btb_hit_o(btb_hit_o),
      .predict_target_o(predict_target_o), .pht_curr_state_o(pht_curr_state_o),
      .predict_taken_o(predict_taken_o)
`ifdef BP_PERF_CNT_EN
      , .lookup_cnt_o(lookup_cnt_o), .btb_hit_cnt_o(btb_hit_cnt_o), .btb_wr_cnt_o(btb_wr_cnt_o)
`endif
   );

   typedef struct packed {
      logic        rs, req, hold;
      logic [31:0] pc;
      logic [12:0] pw;
      logic [62:0] bw;
   } in_t;
   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic        hit;
      logic [31:0] tgt;
      logic [1:0]  st;
      logic        tk;
   } exp_t;
   typedef struct packed {
      in_t  i;
      exp_t e;
   } rec_t;

   int   total = 0, bad = 0;
   int   n_lk = 0, n_hit = 0, n_wr = 0;
   exp_t sb[$];
   exp_t last = '0;

   logic        mv   [128];
   logic [21:0] mtag [128];
   logic [31:0] mtgt [128];
   logic [1:0]  mpht [1024];

   function automatic logic [12:0] pwb(logic we, logic [31:0] pc, logic [1:0] st);
      return {we, pc[12:3], st};
   endfunction

   function automatic logic [62:0] bwb(logic we, logic wv, logic [31:0] pc, logic [31:0] tgt);
      return {we, wv, pc[6:0], pc[28:7], tgt};
   endfunction

   function automatic rec_t r(logic rs, logic req, logic hold, logic [31:0] pc, logic [12:0] pw,
                              logic [62:0] bw, logic v, logic [31:0] epc, logic hit,
                              logic [31:0] tgt, logic [1:0] st, logic tk);
      rec_t x;
      x.i.rs = rs; x.i.req = req; x.i.hold = hold; x.i.pc = pc; x.i.pw = pw; x.i.bw = bw;
      x.e.v = v; x.e.pc = epc; x.e.hit = hit; x.e.tgt = tgt; x.e.st = st; x.e.tk = tk;
      return x;
   endfunction

   function automatic exp_t model(in_t v);
      exp_t        e;
      logic [6:0]  bi;
      logic [9:0]  pi;
      logic        bv;
      logic [21:0] bt;
      logic [31:0] tg;
      logic [1:0]  st;
      e = '0;
      if (v.rs) return e;
      if (v.hold) return last;
      if (!v.req) return e;
      bi = v.pc[6:0];
      pi = v.pc[12:3];
      if (v.bw[62] && v.bw[60:54] == bi) begin
         bv = v.bw[61]; bt = v.bw[53:32]; tg = v.bw[31:0];
      end else begin
         bv = mv[bi]; bt = mtag[bi]; tg = mtgt[bi];
      end
      st = (v.pw[12] && v.pw[11:2] == pi) ? v.pw[1:0] : mpht[pi];
      e.v = 1'b1;
      e.pc = v.pc;
      e.hit = bv && (bt == v.pc[28:7]);
      e.tgt = e.hit ? tg : 32'h0;
      e.st = st;
      e.tk = e.hit & st[1];
      return e;
   endfunction

   task automatic apply(input in_t v);
      if (v.rs) begin
         for (int i = 0; i < 128; i++) mv[i] = 1'b0;
         for (int i = 0; i < 1024; i++) mpht[i] = 2'b01;
      end else begin
         if (v.pw[12]) mpht[v.pw[11:2]] = v.pw[1:0];
         if (v.bw[62]) begin
            mv[v.bw[60:54]] = v.bw[61];
            mtag[v.bw[60:54]] = v.bw[53:32];
            mtgt[v.bw[60:54]] = v.bw[31:0];
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   task automatic cycle(input in_t v, input exp_t e);
      exp_t x;
      reset = v.rs; fs_req_i = v.req; fs_hold_i = v.hold; fs_pc_i = v.pc;
      pht_wbus_i = v.pw; btb_wbus_i = v.bw;
      sb.push_back(e);
      if (v.rs) begin
         n_lk = 0; n_hit = 0; n_wr = 0;
      end else begin
         if (v.req && !v.hold) begin
            n_lk++;
            n_hit += int'(e.hit);
         end
         if (v.bw[62]) n_wr++;
      end
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("pred_valid", 32'(pred_valid_o), 32'(x.v));
      chk("pred_pc", pred_pc_o, x.pc);
      chk("btb_hit", 32'(btb_hit_o), 32'(x.hit));
      chk("target", predict_target_o, x.tgt);
      chk("pht_state", 32'(pht_curr_state_o), 32'(x.st));
      chk("taken", 32'(predict_taken_o), 32'(x.tk));
      last = x;
   endtask

   function automatic logic [31:0] rpc();
      return ($urandom & 32'hE0000000) | 32'h1C000000 | (32'($urandom_range(0, 1)) << 20)
             | (32'($urandom_range(0, 31)) << 3) | 32'($urandom_range(0, 1));
   endfunction

   initial begin
      rec_t tv[23];
      in_t  v;
      for (int i = 0; i < 128; i++) begin
         mv[i] = 1'b0; mtag[i] = '0; mtgt[i] = '0;
      end
      tv[0]  = r(1,0,0,32'h0,'0,'0,                                                 0,32'h0,0,32'h0,2'd0,0);
      tv[1]  = r(0,1,0,32'h1C000000,'0,'0,                                          1,32'h1C000000,0,32'h0,2'd1,0);
      tv[2]  = r(0,0,0,32'h0,pwb(1,32'h1C000040,2'd2),bwb(1,1,32'h1C000040,32'h1C000100),
                                                                                    0,32'h0,0,32'h0,2'd0,0);
      tv[3]  = r(0,1,0,32'h1C000040,'0,'0,                                          1,32'h1C000040,1,32'h1C000100,2'd2,1);
      tv[4]  = r(0,1,0,32'h1C000080,pwb(1,32'h1C000080,2'd3),bwb(1,1,32'h1C000080,32'h1C000200),
                                                                                    1,32'h1C000080,1,32'h1C000200,2'd3,1);
      tv[5]  = r(0,1,0,32'h1C002040,'0,'0,                                          1,32'h1C002040,0,32'h0,2'd2,0);
      tv[6]  = r(0,1,0,32'hFC000040,'0,'0,                                          1,32'hFC000040,1,32'h1C000100,2'd2,1);
      tv[7]  = r(0,1,0,32'h1C000040,'0,bwb(1,0,32'h1C000040,32'h1C000100),          1,32'h1C000040,0,32'h0,2'd2,0);
      tv[8]  = r(0,1,0,32'h1C000080,pwb(1,32'h1C000080,2'd0),'0,                    1,32'h1C000080,1,32'h1C000200,2'd0,0);
      tv[9]  = r(0,1,0,32'h1C000080,pwb(1,32'h1C000088,2'd3),bwb(1,1,32'h1C000001,32'h00001234),
                                                                                    1,32'h1C000080,1,32'h1C000200,2'd0,0);
      tv[10] = r(0,1,0,32'h1C000001,'0,'0,                                          1,32'h1C000001,1,32'h00001234,2'd1,0);
      tv[11] = r(0,1,0,32'h1C000088,'0,'0,                                          1,32'h1C000088,0,32'h0,2'd3,0);
      tv[12] = r(0,1,1,32'h1C000040,pwb(1,32'h1C000088,2'd1),'0,                    1,32'h1C000088,0,32'h0,2'd3,0);
      tv[13] = r(0,0,1,32'h0,'0,bwb(1,1,32'h1C000088,32'hABCD0000),                 1,32'h1C000088,0,32'h0,2'd3,0);
      tv[14] = r(0,1,1,32'h1C000001,'0,'0,                                          1,32'h1C000088,0,32'h0,2'd3,0);
      tv[15] = r(0,1,0,32'h1C000088,'0,'0,                                          1,32'h1C000088,1,32'hABCD0000,2'd1,0);
      tv[16] = r(0,0,0,32'h1C000088,'0,'0,                                          0,32'h0,0,32'h0,2'd0,0);
      tv[17] = r(0,1,0,32'h1C000001,'0,'0,                                          1,32'h1C000001,1,32'h00001234,2'd1,0);
      tv[18] = r(0,1,1,32'h1C000080,'0,'0,                                          1,32'h1C000001,1,32'h00001234,2'd1,0);
      tv[19] = r(1,1,1,32'h1C000080,'0,'0,                                          0,32'h0,0,32'h0,2'd0,0);
      tv[20] = r(0,1,0,32'h1C000080,'0,'0,                                          1,32'h1C000080,0,32'h0,2'd1,0);
      tv[21] = r(0,1,0,32'h1C000001,'0,'0,                                          1,32'h1C000001,0,32'h0,2'd1,0);
      tv[22] = r(0,1,0,32'h1C000040,'0,'0,                                          1,32'h1C000040,0,32'h0,2'd1,0);
      for (int k = 0; k < 23; k++) cycle(tv[k].i, tv[k].e);

      for (int n = 0; n < 400; n++) begin
         v.rs   = (n == 0) || ($urandom_range(0, 63) == 0);
         v.req  = ($urandom_range(0, 3) != 0);
         v.hold = ($urandom_range(0, 4) == 0);
         v.pc   = rpc();
         v.pw   = pwb(1'($urandom_range(0, 1)), rpc(), 2'($urandom_range(0, 3)));
         v.bw   = bwb(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, rpc(), $urandom);
         cycle(v, model(v));
         apply(v);
      end

`ifdef BP_PERF_CNT_EN
      chk("lookup_cnt", lookup_cnt_o, 32'(n_lk));
      chk("btb_hit_cnt", btb_hit_cnt_o, 32'(n_hit));
      chk("btb_wr_cnt", btb_wr_cnt_o, 32'(n_wr));
      force dut.lookup_cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.lookup_cnt_q;
      v = '0;
      v.req = 1'b1;
      v.pc = 32'h1C000040;
      cycle(v, model(v));
      apply(v);
      chk("lookup_cnt_sat", lookup_cnt_o, 32'hFFFFFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bp_predictor.md
Name: bp_predictor

Overview:
- Fetch-side branch predictor. It holds the PHT (1024 x 2-bit saturating counters) and the BTB (128 direct-mapped entries).
- It answers one prediction lookup per cycle for the fetch PC.
- Its only update path is the pht_wbus/btb_wbus write buses driven by the execute-stage branch resolution unit.
- Lookup indices and tags are bit-identical to the ones the writer places on the buses, so read and write always address the same entry.

Parameters:
- PHT_DEPTH, 1024, PHT entries; index = pc[12:3]
- BTB_DEPTH, 128, BTB entries; index = pc[6:0]
- BTB_TAG_W, 22, BTB tag width; tag = pc[28:7]
- PHT_INIT, 2'b01, PHT reset state (WEAK_NOT_TAKEN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fs_req_i  in  1  lookup request valid this cycle
- fs_pc_i  in  32  fetch PC to predict
- fs_hold_i  in  1  fetch stalled: hold the registered prediction
- pht_wbus_i  in  13  {we[12], idx[11:2]=pc[12:3], next_state[1:0]}
- btb_wbus_i  in  63  {we[62], wvalid[61], waddr[60:54]=pc[6:0], wtag[53:32]=pc[28:7], wtarget[31:0]}
- pred_valid_o  out  1  prediction outputs correspond to a lookup
- pred_pc_o  out  32  PC the prediction belongs to
- btb_hit_o  out  1  BTB entry valid and tag match
- predict_target_o  out  32  BTB target (0 when no hit)
- pht_curr_state_o  out  2  PHT counter read for pred_pc_o
- predict_taken_o  out  1  btb_hit_o & pht_curr_state_o[1]

Behaviour:
- Encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. The next_state field on the bus is written as-is; this block performs no counter arithmetic.
- Reset (sync, high):
  - every BTB valid bit = 0 and every PHT entry = PHT_INIT
  - all outputs = 0
  - BTB tag and target storage is not reset
  - Reset asserted mid-stream drops the in-flight lookup. pred_valid_o is 0 in the cycle after reset.
- Lookup latency is 1 cycle: request at edge N, outputs valid after edge N+1, held in output registers.
- fs_hold_i = 1:
  - all output registers keep their values
  - table writes still proceed
  - the new fs_req_i is ignored, because fetch re-presents it
- fs_hold_i = 0 and fs_req_i = 0: pred_valid_o <= 0; the other outputs are don't-care but are driven to 0.
- Hit rule: btb_valid[pc[6:0]] & (btb_tag[pc[6:0]] == pc[28:7]). pc[31:29] is not compared.
- Write timing:
  - PHT write when pht_wbus we = 1; BTB write when btb_wbus we = 1; both commit at the clock edge.
  - A BTB write sets valid to wvalid.
  - PHT and BTB writes in the same cycle are independent.
- Read/write collision, write-first: if a write targets the same index as the lookup in the same cycle, the lookup returns the newly written data.
  - BTB: wvalid, wtag and wtarget are used in the hit compare.
  - PHT: next_state is used.
  - This is required so back-to-back loop branches see their update.
- Tag and index are reused across different PCs: an aliased PHT index shares its counter; no disambiguation is done.
- No internal FSM beyond the output pipeline register and the stats counters; storage is flops or LUTRAM with async read.

Optional Feature:
- Macro BP_PERF_CNT_EN.
- When defined, adds three outputs, all 32-bit saturating (stick at 32'hFFFFFFFF) and reset to 0:
  - lookup_cnt_o: +1 per accepted lookup (fs_req_i & ~fs_hold_i)
  - btb_hit_cnt_o: +1 per accepted lookup that hits
  - btb_wr_cnt_o: +1 per btb_wbus write with we = 1
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then lookup pc=0x1C000000 -> next cycle pred_valid_o=1, btb_hit_o=0, pht_curr_state_o=01, predict_taken_o=0, predict_target_o=0.
- BTB write (pc 0x1C000040, target 0x1C000100, wvalid=1) plus PHT write idx 0x008 state 10, then lookup 0x1C000040 -> btb_hit_o=1, predict_target_o=0x1C000100, predict_taken_o=1.
- Same-cycle write and lookup of 0x1C000080 (state 11, target 0x1C000200) -> the prediction that cycle shows hit, state 11, target 0x1C000200 (write-first).
- Lookup 0x1C002040 after the scenario-2 write (same index, different tag) -> btb_hit_o=0, predict_taken_o=0, pht_curr_state_o=10 (aliased counter).
- Hold fs_hold_i=1 for 3 cycles while changing fs_pc_i -> outputs unchanged. Assert reset mid-hold -> outputs 0 and all BTB entries miss afterwards.
- With BP_PERF_CNT_EN: 5 lookups with 2 hits and 3 BTB writes -> lookup_cnt_o=5, btb_hit_cnt_o=2, btb_wr_cnt_o=3. Force a counter to 32'hFFFFFFFF -> it stays saturated.
